// File: rtl/oven_cook_sequencer.sv
// oven_cook_sequencer: sequences one bake cycle (preheat, timed cook, alarm) with heater hysteresis and fault handling
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_tick_1hz              one-cycle pulse per second
//   i_start, i_cancel       start request / abort to IDLE
//   i_door_open             1 = door open
//   i_target_temp/time      requested temperature (°F) / cook time (s)
//   i_current_temp          sensor reading (°F)
//   o_heater_on, o_fan_on   relay drives
//   o_time_remaining        seconds left in the cook phase
//   o_state                 IDLE=0 PREHEAT=1 COOK=2 PAUSE=3 DONE=4 FAULT=5
//   o_preheat_done, o_alarm status / buzzer
module oven_cook_sequencer #(
    parameter int HYST       = 10,
    parameter int MAX_TEMP   = 550,
    parameter int ALARM_SECS = 5
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_tick_1hz,
    input  logic        i_start,
    input  logic        i_cancel,
    input  logic        i_door_open,
    input  logic [9:0]  i_target_temp,
    input  logic [12:0] i_target_time,
    input  logic [9:0]  i_current_temp,
    output logic        o_heater_on,
    output logic        o_fan_on,
    output logic [12:0] o_time_remaining,
    output logic [2:0]  o_state,
    output logic        o_preheat_done,
    output logic        o_alarm
);
    localparam int AW = $clog2(ALARM_SECS + 1);
    typedef enum logic [2:0] {IDLE = 3'd0, PREHEAT = 3'd1, COOK = 3'd2, PAUSE = 3'd3, DONE = 3'd4, FAULT = 3'd5} state_t;
    state_t r_state, w_next, r_ret, w_ret;
    logic [9:0]    r_ttemp, w_ttemp;
    logic [12:0]   r_time, w_time;
    logic [AW-1:0] r_acnt, w_acnt;
    logic          r_heater, w_heater, r_fan, r_alarm, r_pd, w_pd;
    logic          w_over, w_cold;
    // The latched cook time lives in r_time: it is loaded on start and only counts down afterwards.
    always_comb begin
        w_over   = i_current_temp > 10'(MAX_TEMP);
        // Lower hysteresis edge saturates at 0; below that band only a 0 °F reading re-enables the heater.
        w_cold   = (r_ttemp >= 10'(HYST)) ? (i_current_temp < r_ttemp - 10'(HYST)) : (i_current_temp == 10'd0);
        w_next   = r_state;
        w_ret    = r_ret;
        w_ttemp  = r_ttemp;
        w_time   = r_time;
        w_acnt   = r_acnt;
        if (i_cancel && r_state != FAULT) begin
            w_next = IDLE;
            w_time = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_time = i_target_time;
                    if (i_start && !i_door_open && i_target_time != '0) begin
                        w_next  = PREHEAT;
                        w_ttemp = i_target_temp;
                    end
                end
                PREHEAT: begin
                    if (w_over) w_next = FAULT;
                    else if (i_door_open) begin
                        w_next = PAUSE;
                        w_ret  = PREHEAT;
                    end else if (i_current_temp >= r_ttemp) w_next = COOK;
                end
                COOK: begin
                    if (w_over) w_next = FAULT;
                    else if (i_door_open) begin
                        w_next = PAUSE;
                        w_ret  = COOK;
                    end else if (i_tick_1hz && r_time != '0) begin
                        w_time = r_time - 13'd1;
                        w_acnt = '0;
                        if (r_time == 13'd1) w_next = DONE;
                    end
                end
                PAUSE: begin
                    if (w_over) w_next = FAULT;
                    else if (!i_door_open) w_next = r_ret;
                end
                DONE: begin
                    if (i_tick_1hz) begin
                        if (r_acnt == AW'(ALARM_SECS - 1)) w_next = IDLE;
                        else w_acnt = r_acnt + AW'(1);
                    end
                end
                FAULT: begin
                    if (i_cancel && !w_over) begin
                        w_next = IDLE;
                        w_time = '0;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
        // Outputs are computed for the state being entered so they register alongside it.
        w_heater = (w_next == PREHEAT) ? 1'b1 :
                   (w_next != COOK) ? 1'b0 :
                   (i_current_temp >= r_ttemp) ? 1'b0 :
                   w_cold ? 1'b1 : r_heater;
        w_pd     = (w_next == IDLE) ? 1'b0 : (w_next == COOK) ? 1'b1 : r_pd;
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_ret    <= IDLE;
            r_ttemp  <= '0;
            r_time   <= '0;
            r_acnt   <= '0;
            r_heater <= 1'b0;
            r_fan    <= 1'b0;
            r_alarm  <= 1'b0;
            r_pd     <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_ret    <= w_ret;
            r_ttemp  <= w_ttemp;
            r_time   <= w_time;
            r_acnt   <= w_acnt;
            r_heater <= w_heater;
            r_fan    <= w_next == COOK || w_next == DONE || w_next == FAULT;
            r_alarm  <= w_next == DONE || w_next == FAULT;
            r_pd     <= w_pd;
        end
    end
    assign o_heater_on      = r_heater;
    assign o_fan_on         = r_fan;
    assign o_time_remaining = r_time;
    assign o_state          = r_state;
    assign o_preheat_done   = r_pd;
    assign o_alarm          = r_alarm;
endmodule

// File: tb/tb_oven_cook_sequencer.sv
// tb_oven_cook_sequencer: directed stimulus checked every cycle against a behavioural model plus literal expectations
module tb_oven_cook_sequencer;
    localparam int HYST = 10, MAX_TEMP = 550, ALARM_SECS = 5;
    localparam int IDL = 0, PRE = 1, CK = 2, PAU = 3, DN = 4, FLT = 5;
    logic        clk = 0, rst_n = 0, tick = 0, start = 0, cancel = 0, door = 0;
    logic [9:0]  ttemp = 300, cur = 70;
    logic [12:0] ttime = 3;
    logic        heater, fan, pd, alarm;
    logic [12:0] trem;
    logic [2:0]  st;
    int n_cmp = 0, n_bad = 0;
    int m_ph = 0, m_ret = 0, m_tt = 0, m_tr = 0, m_ac = 0, m_h = 0, m_pd = 0;
    bit hot;

    oven_cook_sequencer #(.HYST(HYST), .MAX_TEMP(MAX_TEMP), .ALARM_SECS(ALARM_SECS)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick_1hz(tick), .i_start(start), .i_cancel(cancel),
        .i_door_open(door), .i_target_temp(ttemp), .i_target_time(ttime), .i_current_temp(cur),
        .o_heater_on(heater), .o_fan_on(fan), .o_time_remaining(trem), .o_state(st),
        .o_preheat_done(pd), .o_alarm(alarm));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int n);
        repeat (n) begin
            tick = 1;
            step(1);
            tick = 0;
            step(1);
        end
    endtask

    // Model: phase-level rules in priority order, outputs derived from the resulting phase.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_ph = IDL; m_ret = IDL; m_tt = 0; m_tr = 0; m_ac = 0; m_h = 0; m_pd = 0;
        end else begin
            hot = cur > MAX_TEMP;
            if (cancel && m_ph != FLT) begin
                m_ph = IDL; m_tr = 0;
            end else if (m_ph == IDL) begin
                m_tr = ttime;
                if (start && !door && ttime != 0) begin m_tt = ttemp; m_ph = PRE; end
            end else if (m_ph == FLT) begin
                if (cancel && !hot) begin m_ph = IDL; m_tr = 0; end
            end else if (m_ph == DN) begin
                if (tick) begin m_ac++; if (m_ac == ALARM_SECS) m_ph = IDL; end
            end else if (hot) m_ph = FLT;
            else if (m_ph == PAU) begin
                if (!door) m_ph = m_ret;
            end else if (door) begin
                m_ret = m_ph; m_ph = PAU;
            end else if (m_ph == PRE) begin
                if (cur >= m_tt) m_ph = CK;
            end else if (tick) begin
                m_tr--;
                if (m_tr == 0) begin m_ph = DN; m_ac = 0; end
            end
            m_h = m_ph == PRE ? 1 : m_ph != CK ? 0 : cur >= m_tt ? 0 :
                  (m_tt < HYST ? cur == 0 : cur < m_tt - HYST) ? 1 : m_h;
            m_pd = m_ph == IDL ? 0 : m_ph == CK ? 1 : m_pd;
        end
        #1;
        chk("state", st, m_ph);
        chk("heater", heater, m_h);
        chk("fan", fan, int'(m_ph == CK || m_ph == DN || m_ph == FLT));
        chk("alarm", alarm, int'(m_ph == DN || m_ph == FLT));
        chk("time", trem, m_tr);
        chk("pd", pd, m_pd);
    end

    initial begin
        step(2);
        chk("rst_state", st, 0);
        chk("rst_time", trem, 0);
        chk("rst_heater", heater, 0);
        rst_n = 1;
        step(1);
        chk("idle_mirror", trem, 3);
        // normal cycle
        cur = 250; start = 1;
        step(1);
        start = 0;
        chk("pre_state", st, 1);
        chk("pre_heater", heater, 1);
        cur = 270; step(1);
        cur = 290; step(1);
        cur = 300; step(1);
        chk("cook_state", st, 2);
        chk("cook_pd", pd, 1);
        pulse(3);
        chk("done_state", st, 4);
        chk("done_alarm", alarm, 1);
        chk("done_time", trem, 0);
        pulse(4);
        chk("done_hold", st, 4);
        pulse(1);
        chk("done_exit", st, 0);
        chk("done_exit_alarm", alarm, 0);
        chk("done_exit_pd", pd, 0);
        // hysteresis
        ttime = 20; start = 1;
        step(1);
        start = 0;
        step(1);
        chk("hy_300", heater, 0);
        cur = 295; step(1); chk("hy_295a", heater, 0);
        cur = 289; step(1); chk("hy_289", heater, 1);
        cur = 295; step(1); chk("hy_295b", heater, 1);
        cur = 300; step(1); chk("hy_300b", heater, 0);
        // pause / resume
        pulse(10);
        chk("t10", trem, 10);
        cur = 295; door = 1;
        step(1);
        chk("pause_state", st, 3);
        chk("pause_heater", heater, 0);
        pulse(4);
        chk("pause_time", trem, 10);
        door = 0;
        step(1);
        chk("resume_state", st, 2);
        pulse(1);
        chk("resume_time", trem, 9);
        pulse(8);
        chk("t1", trem, 1);
        door = 1; tick = 1;
        step(1);
        tick = 0;
        chk("door_wins_state", st, 3);
        chk("door_wins_time", trem, 1);
        door = 0; cancel = 1;
        step(1);
        cancel = 0;
        chk("cancel_state", st, 0);
        chk("cancel_time", trem, 0);
        // low target below hysteresis band
        ttemp = 5; ttime = 3; cur = 0; start = 1;
        step(1);
        start = 0;
        cur = 5; step(1); chk("lo_cook", st, 2);
        cur = 3; step(1); chk("lo_hold", heater, 0);
        cur = 0; step(1); chk("lo_zero", heater, 1);
        cancel = 1; step(1); cancel = 0;
        // over-temperature fault
        ttemp = 300; ttime = 5; cur = 250; start = 1;
        step(1);
        start = 0;
        cur = 560;
        step(1);
        chk("flt_state", st, 5);
        chk("flt_heater", heater, 0);
        chk("flt_fan", fan, 1);
        chk("flt_alarm", alarm, 1);
        pulse(1);
        chk("flt_time", trem, 5);
        cancel = 1;
        step(1);
        chk("flt_hot_cancel", st, 5);
        cur = 540;
        step(1);
        chk("flt_exit", st, 0);
        cancel = 0;
        step(1);
        // ignored starts
        ttime = 0; start = 1;
        step(1);
        chk("start_t0", st, 0);
        ttime = 5; door = 1;
        step(1);
        chk("start_door", st, 0);
        door = 0; cancel = 1;
        step(1);
        chk("start_cancel", st, 0);
        chk("start_cancel_time", trem, 0);
        cancel = 0; start = 0;
        step(1);
        chk("idle_mirror5", trem, 5);
        // reset mid-cook; target changes after start are ignored
        ttime = 42; cur = 300; start = 1;
        step(1);
        start = 0;
        step(1);
        ttime = 7;
        step(1);
        chk("cook42", trem, 42);
        rst_n = 0;
        step(1);
        chk("mid_rst_state", st, 0);
        chk("mid_rst_time", trem, 0);
        chk("mid_rst_outs", {heater, fan, pd, alarm}, 0);
        rst_n = 1;
        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
